// File: rtl/uart_tx_serializer.sv
// Purpose : serialize one W_BUS result bus into N_WORDS UART packets on an idle-high line.
// Latency : tx shows the start bit of packet 0 one cycle after the handshake edge.
// Backpressure: s_ready is held low for the whole N_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE
//              cycle transfer; the line itself has no flow control.
// Ports: clk, rstn (async active-low) | s_valid/s_ready/s_data bus input | tx serial out.
module uart_tx_serializer #(
  parameter  int CLOCKS_PER_PULSE = 33,
  parameter  int BITS_PER_WORD    = 8,
  parameter  int PACKET_SIZE      = 13,
  parameter  int W_BUS            = 16,
  localparam int N_WORDS          = W_BUS / BITS_PER_WORD
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_BUS-1:0] s_data,
  output logic             tx
);

  localparam int NBITS = N_WORDS * PACKET_SIZE;
  localparam int PW    = $clog2(CLOCKS_PER_PULSE);
  localparam int BW    = $clog2(NBITS);

  localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  if (W_BUS % BITS_PER_WORD != 0) begin : g_chk_bus
    $error("W_BUS must be a multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_chk_pkt
    $error("PACKET_SIZE must be at least BITS_PER_WORD+2");
  end
  if (CLOCKS_PER_PULSE < 2) begin : g_chk_cpp
    $error("CLOCKS_PER_PULSE must be at least 2");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  shreg_q, shreg_d;
  logic [PW-1:0]     pulse_q, pulse_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic [NBITS-1:0]  frame;

  // Whole transfer laid out LSB-first: per packet a 0 start bit, the word,
  // then padding ones that double as the stop bits.
  always_comb begin
    frame = '1;
    for (int i = 0; i < N_WORDS; i++) begin
      frame[i*PACKET_SIZE] = 1'b0;
      frame[i*PACKET_SIZE+1 +: BITS_PER_WORD] = s_data[i*BITS_PER_WORD +: BITS_PER_WORD];
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pulse_d = pulse_q;
    bit_d   = bit_q;
    s_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_d = SEND;
          shreg_d = frame;
          pulse_d = '0;
          bit_d   = '0;
        end
      end
      SEND: begin
        if (pulse_q == PULSE_LAST) begin
          pulse_d = '0;
          // Fill with ones so the line idles high behind the last bit.
          shreg_d = {1'b1, shreg_q[NBITS-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          pulse_d = pulse_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from next-state values so the pin never glitches and
    // the start bit appears exactly one cycle after the handshake.
    tx_d = (state_d == SEND) ? shreg_d[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pulse_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pulse_q <= pulse_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-UART transmitter for the matrix-vector accelerator's output path. It accepts one result bus (R*W_Y_OUT bits) per valid/ready handshake, splits it into BITS_PER_WORD words, and serializes them on a single idle-high line. Each word is sent LSB-first in a fixed-length packet of one start bit, the data bits, and stop/padding bits. It is the transmit counterpart of the system's UART receive deserializer, and its output drives the chip's serial TX pin.

## Interface
Parameters:
- CLOCKS_PER_PULSE, 33: clock cycles per UART bit.
- BITS_PER_WORD, 8: data bits per packet.
- PACKET_SIZE, 13: total bits per packet (1 start + BITS_PER_WORD data + stop/padding); must be ≥ BITS_PER_WORD+2.
- W_BUS, 16: input bus width (R*W_Y_OUT); must be a multiple of BITS_PER_WORD.
- N_WORDS, W_BUS/BITS_PER_WORD (derived): packets per transfer.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input bus valid.
- s_ready  out  1  block can accept a bus.
- s_data  in  W_BUS  result bus; word i = s_data[i*BITS_PER_WORD +: BITS_PER_WORD].
- tx  out  1  serial line, idle high.

## Operation
- States:
  - IDLE: s_ready=1, tx=1.
  - SEND: s_ready=0.
- Handshake: a transfer is accepted when s_valid && s_ready at a rising edge.
  - On acceptance, load a shift register of N_WORDS*PACKET_SIZE bits.
  - Packet i, LSB-first, is {(PACKET_SIZE-BITS_PER_WORD-1) ones, word i, 1'b0}.
  - Packet 0 is first on the line.
- SEND: tx is the registered LSB of the shift register.
  - A pulse counter runs 0..CLOCKS_PER_PULSE-1.
  - At the counter's wrap, shift right by one and increment a bit counter.
  - After the bit counter reaches N_WORDS*PACKET_SIZE-1 and the pulse counter wraps, return to IDLE.
- s_data is latched at the handshake. Changes on s_data or s_valid during SEND are ignored.
- No parity and no flow control on tx.
- The counters are sized with $clog2. Counters never wrap mid-transfer.
- Reset (async, any time, including mid-frame):
  - tx=1 and s_ready=1 immediately.
  - Both counters and the shift register are cleared.
  - The partial frame is abandoned and never resumed.
- Elaboration-time checks: W_BUS % BITS_PER_WORD == 0, PACKET_SIZE ≥ BITS_PER_WORD+2, CLOCKS_PER_PULSE ≥ 2.

## Timing
- Reset values: tx=1, s_ready=1, state IDLE.
- Let T = N_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE (858 at defaults).
- For a handshake at edge E0:
  - tx falls to 0 (start of packet 0) right after E0, giving 1 cycle of latency.
  - Bit j is held on tx exactly during cycles [E0+j*CLOCKS_PER_PULSE, E0+(j+1)*CLOCKS_PER_PULSE).
  - s_ready is low after E0 and rises after edge E0+T, together with tx returning to or staying at 1.
- Back-to-back transfers with s_valid held:
  - The next handshake occurs at edge E0+T+1.
  - Consecutive start-bit falling edges are therefore T+1 cycles apart, with at least one idle-high cycle.
- Between packets of one transfer there is no gap beyond the padding bits. The start bit of packet i+1 begins exactly PACKET_SIZE*CLOCKS_PER_PULSE cycles after that of packet i.
- Throughput: one bus per T+1 cycles.

## Test plan
- **Reset:** hold rstn=0 for 3 cycles, then release with s_valid=0 for 200 cycles → tx=1 and s_ready=1 throughout.
- **Single transfer, s_data=16'hA53C:**
  - Sample mid-bit → packet 0 is start 0, data 0,0,1,1,1,1,0,0, then 4 ones.
  - Packet 1 carries 0xA5.
  - s_ready is low for exactly 858 cycles.
  - Each bit lasts exactly 33 cycles, measured edge-to-edge.
- **Back-to-back:** s_valid held high with 16'h0001 then 16'hFFFF → both words decode correctly, and the second transfer's start bit falls 859 cycles after the first transfer's start bit.
- **Input stability:** s_data changed to 16'h0000 every cycle during SEND after accepting 16'h5AC3 → the line carries 0xC3, 0x5A.
- **Reset mid-frame:**
  - Assert rstn=0 during bit 5 of packet 1 → tx=1 and s_ready=1 within the same cycle (async).
  - After release, a transfer of 16'h1234 → 0x34, 0x12 are transmitted with correct framing.
- **Data extremes:** 16'h0000 and 16'hFFFF →
  - The start bit is always 0.
  - All padding bits are 1 (checked at each bit middle).
  - There are no extra tx transitions inside a bit period.
